// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider: registered divided clock plus a
// one-cycle tick at the start of each output period; divisor swaps only at period edges.
module clock_divider_prog #(
  parameter int CNT_WIDTH   = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] div_value,
  input  logic                 div_load,
  output logic                 div_busy,
  output logic                 div_err,
  output logic                 clock_out,
  output logic                 tick
);

  generate
    if ((DEFAULT_DIV < 2) || (DEFAULT_DIV > ((2 ** CNT_WIDTH) - 1))) begin : g_bad_default_div
      $error("clock_divider_prog: DEFAULT_DIV out of range 2..2^CNT_WIDTH-1");
    end
  endgenerate

  localparam logic [CNT_WIDTH-1:0] DEF_DIV = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] MIN_DIV = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH:0]   ONE_X   = {{CNT_WIDTH{1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic [CNT_WIDTH-1:0] div_active_q, div_active_d;
  logic [CNT_WIDTH-1:0] div_pending_q, div_pending_d;
  logic                 div_busy_q, div_busy_d;
  logic                 div_err_q, div_err_d;
  logic                 clock_out_q, clock_out_d;
  logic                 tick_q, tick_d;

  logic [CNT_WIDTH:0]   cnt_next_x_s;
  logic [CNT_WIDTH:0]   active_x_s;
  logic [CNT_WIDTH:0]   half_sum_s;
  logic [CNT_WIDTH:0]   half_s;
  logic                 at_wrap_s;
  logic                 apply_s;

  // Next-state logic for counter, outputs and the divisor load/apply handshake.
  always_comb begin
    counter_d     = counter_q;
    div_active_d  = div_active_q;
    div_pending_d = div_pending_q;
    div_busy_d    = div_busy_q;
    div_err_d     = div_err_q;
    clock_out_d   = clock_out_q;
    tick_d        = 1'b0;

    // Extra bit keeps H and the wrap compare exact at the maximum divisor.
    cnt_next_x_s = {1'b0, counter_q} + ONE_X;
    active_x_s   = {1'b0, div_active_q};
    half_sum_s   = active_x_s + ONE_X;
    half_s       = {1'b0, half_sum_s[CNT_WIDTH:1]};
    // ">=" rather than "==" so a counter left beyond a shorter divisor applied while frozen still wraps.
    at_wrap_s    = (cnt_next_x_s >= active_x_s);
    apply_s      = div_busy_q && (!enable || at_wrap_s);

    if (enable) begin
      counter_d   = at_wrap_s ? ZERO : cnt_next_x_s[CNT_WIDTH-1:0];
      clock_out_d = ({1'b0, counter_q} < half_s);
      tick_d      = (counter_q == ZERO);
    end else begin
      counter_d   = counter_q;
      clock_out_d = clock_out_q;
    end

    if (apply_s) begin
      div_active_d = div_pending_q;
      div_busy_d   = 1'b0;
    end else begin
      div_active_d = div_active_q;
    end

    // Evaluated after apply so a load on the apply edge stays pending.
    if (div_load) begin
      if (div_value >= MIN_DIV) begin
        div_pending_d = div_value;
        div_busy_d    = 1'b1;
        div_err_d     = 1'b0;
      end else begin
        div_err_d     = 1'b1;
      end
    end else begin
      div_err_d = div_err_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      counter_q     <= ZERO;
      div_active_q  <= DEF_DIV;
      div_pending_q <= DEF_DIV;
      div_busy_q    <= 1'b0;
      div_err_q     <= 1'b0;
      clock_out_q   <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      counter_q     <= counter_d;
      div_active_q  <= div_active_d;
      div_pending_q <= div_pending_d;
      div_busy_q    <= div_busy_d;
      div_err_q     <= div_err_d;
      clock_out_q   <= clock_out_d;
      tick_q        <= tick_d;
    end
  end

  assign div_busy  = div_busy_q;
  assign div_err   = div_err_q;
  assign clock_out = clock_out_q;
  assign tick      = tick_q;

endmodule
